// File: rtl/rr_arbiter_8.sv
// 8-requester arbiter with round-robin or fixed-priority selection,
// grant hold while the owner keeps requesting, and optional preemption after MAX_HOLD cycles.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       fixed_pri,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    // Saturation point of the hold counter; equals MAX_HOLD when preemption is enabled
    localparam logic [HOLD_W-1:0] HOLD_SAT =
        (MAX_HOLD != 0) ? HOLD_W'(MAX_HOLD) : {HOLD_W{1'b1}};

    state_t            state;
    logic [2:0]        ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic [7:0] others;
    logic [7:0] cand;
    logic       owner_req;
    logic       hold_full;
    logic       take_new;
    logic       go_idle;
    logic [2:0] win_id;
    logic [2:0] idx;

    always_comb begin
        others    = req & ~(8'd1 << gnt_id);
        owner_req = req[gnt_id];
        hold_full = (MAX_HOLD != 0) && (hold_cnt == HOLD_SAT);
        cand      = (state == IDLE) ? req : others;
        if (state == IDLE) begin
            take_new = |req;
            go_idle  = 1'b0;
        end else begin
            take_new = (|others) && (!owner_req || hold_full);
            go_idle  = !owner_req && !(|others);
        end
    end

    // Loops run so the winning candidate is the last one assigned
    always_comb begin
        win_id = '0;
        idx    = '0;
        if (fixed_pri) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (cand[i]) win_id = 3'(i);
            end
        end else begin
            for (int unsigned k = 8; k > 0; k--) begin
                idx = ptr + 3'(k - 1);
                if (cand[idx]) win_id = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else if (take_new) begin
            state     <= GRANT;
            gnt       <= 8'd1 << win_id;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            ptr       <= win_id + 3'd1;
            hold_cnt  <= HOLD_W'(1);
        end else if (go_idle) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
        end else if (state == GRANT && hold_cnt != HOLD_SAT) begin
            hold_cnt  <= hold_cnt + HOLD_W'(1);
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboarded bench for rr_arbiter_8: directed scenarios plus randomized traffic
// checked against an owner/pointer reference model.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 8;

    typedef struct {
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'hFF;
    logic       fixed_pri = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;

    logic [7:0] rr_req [9] = '{8'h0F, 8'h0F, 8'h0E, 8'h0F, 8'h0D, 8'h0F, 8'h0B, 8'h0F, 8'h07};
    logic [7:0] rr_exp [9] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h04, 8'h04, 8'h08, 8'h08, 8'h01};

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .fixed_pri(fixed_pri),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] c, input bit fp, input int p);
        if (fp) begin
            for (int i = 7; i >= 0; i--) if (c[i]) return i;
        end else begin
            for (int k = 0; k < 8; k++) if (c[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
    endtask

    task automatic award(input logic [7:0] c, input bit fp);
        m_owner = pick(c, fp, m_ptr);
        m_ptr   = (m_owner + 1) % 8;
        m_held  = 1;
    endtask

    task automatic model_step(input logic [7:0] r, input bit fp, input bit rst);
        logic [7:0] others;
        exp_t e;
        if (!rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            if (r != 0) award(r, fp);
        end else begin
            others = r;
            others[m_owner] = 1'b0;
            if (!r[m_owner]) begin
                if (others != 0) award(others, fp);
                else begin m_owner = -1; m_held = 0; end
            end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD && others != 0) begin
                award(others, fp);
            end else begin
                m_held++;
            end
        end
        if (m_owner < 0) begin
            e.g = 8'h00; e.id = 3'd0; e.v = 1'b0;
        end else begin
            e.g = 8'd1 << m_owner; e.id = 3'(m_owner); e.v = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the response due at the next rising edge
    task automatic cycle(input logic [7:0] r, input bit fp, input bit rst);
        @(negedge clk);
        req = r;
        fixed_pri = fp;
        rst_n = rst;
        model_step(r, fp, rst);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (gnt !== e.g || gnt_id !== e.id || gnt_valid !== e.v) begin
                    errors++;
                    $display("FAIL scoreboard gnt=%h id=%0d valid=%b expected gnt=%h id=%0d valid=%b at %0t",
                             gnt, gnt_id, gnt_valid, e.g, e.id, e.v, $time);
                end
            end
        end
    end

    initial begin : driver
        logic [7:0] hist [12];
        int run;
        bit ok;
        bit fp;
        logic [7:0] r;

        for (int i = 0; i < 3; i++) cycle(8'hFF, 0, 0);
        @(posedge clk); #1;
        chk("reset_gnt", gnt, 8'h00);
        chk("reset_valid", gnt_valid, 0);
        for (int i = 0; i < 5; i++) cycle(8'h00, 0, 1);
        @(posedge clk); #1;
        chk("idle_valid", gnt_valid, 0);

        for (int i = 0; i < 9; i++) begin
            cycle(rr_req[i], 0, 1);
            @(posedge clk); #1;
            chk("rr_gnt", gnt, rr_exp[i]);
        end
        cycle(8'h00, 0, 1);

        cycle(8'hA4, 1, 1);
        @(posedge clk); #1;
        chk("fixed_gnt7", gnt, 8'h80);
        chk("fixed_id7", gnt_id, 7);
        cycle(8'h24, 1, 1);
        @(posedge clk); #1;
        chk("fixed_gnt5", gnt, 8'h20);
        chk("fixed_id5", gnt_id, 5);
        cycle(8'h00, 0, 1);

        for (int n = 0; n < 12; n++) begin
            cycle((n < 3) ? 8'h01 : 8'h11, 0, 1);
            @(posedge clk); #1;
            hist[n] = gnt;
        end
        run = 0;
        while (run < 12 && hist[run] == 8'h01) run++;
        chk("preempt_len", run, 8);
        chk("preempt_to", hist[8], 8'h10);
        cycle(8'h00, 0, 1);

        ok = 1'b1;
        for (int n = 0; n < 25; n++) begin
            cycle(8'h01, 0, 1);
            @(posedge clk); #1;
            if (gnt !== 8'h01) ok = 1'b0;
        end
        chk("lone_hold", ok, 1);
        cycle(8'h00, 0, 1);

        cycle(8'h40, 0, 1);
        @(posedge clk); #1;
        chk("wrap_g6", gnt, 8'h40);
        cycle(8'h81, 0, 1);
        @(posedge clk); #1;
        chk("wrap_g7", gnt, 8'h80);
        cycle(8'h00, 0, 1);
        cycle(8'h81, 0, 1);
        @(posedge clk); #1;
        chk("wrap_g0", gnt, 8'h01);

        cycle(8'h08, 0, 1);
        @(posedge clk); #1;
        chk("pre_rst_gnt", gnt, 8'h08);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_gnt", gnt, 8'h00);
        chk("async_id", gnt_id, 0);
        chk("async_valid", gnt_valid, 0);
        #1;
        rst_n = 1'b1;
        cycle(8'h0C, 0, 1);
        @(posedge clk); #1;
        chk("post_rst_gnt", gnt, 8'h04);

        fp = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(15) == 0) fp = ~fp;
            case ($urandom_range(3))
                0: r = 8'($urandom);
                1: r = 8'($urandom) & 8'($urandom);
                2: r = 8'($urandom) & 8'($urandom) & 8'($urandom);
                default: r = req;
            endcase
            cycle(r, fp, ($urandom_range(99) != 0));
        end
        cycle(8'h00, 0, 1);
        @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
